alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised sequential ALU for the CSE141L core, the successor to the combinational single-width datapath ALU. It accepts one operation per START strobe. Most operations complete in one clock. Multiply and multi-bit shifts iterate over several clocks. The carry, equal and greater-than flags are registered inside the block, so multi-precision add/subtract chains without an external carry path. It sits between the register file read ports and the writeback/branch logic.

## Interface
Parameters:
- WIDTH, 8: operand and result width, ≥ 4, power of two
- IMM_W, 5: immediate width for ADDi, ≤ WIDTH
- SIGNED_CMP, 0: 1 selects two's-complement compare for BGT

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  issue strobe, sampled only when BUSY=0
- OP  in  4  opcode, type alu_op_t
- INPUTA  in  WIDTH  operand A
- INPUTB  in  WIDTH  operand B; shift count for SHLN/SHRN
- IMM  in  IMM_W  immediate, zero-extended
- USE_CARRY  in  1  ADD/SUB chain with the carry flag
- BUSY  out  1  multi-cycle operation in progress
- DONE  out  1  one-cycle pulse: OUT and flags are valid
- OUT  out  WIDTH  result, registered, held until next DONE
- OUT_HI  out  WIDTH  upper half of the MUL product, held
- SC_OUT  out  1  registered carry flag
- BEQ  out  1  registered equal flag
- BGT  out  1  registered greater-than flag

## Operation
- Operands, OP and USE_CARRY are captured when START is accepted. Later input changes have no effect.
- C denotes the current SC_OUT flag.
- ADD: {SC_OUT,OUT} = A + B + (USE_CARRY ? C : 0).
- SUB: {SC_OUT,OUT} = A + ~B + (USE_CARRY ? C : 1). SC_OUT=1 means no borrow.
- ADDi: {SC_OUT,OUT} = A + zext(IMM).
- LSH: {SC_OUT,OUT} = {A,0}.
- LSHC: {SC_OUT,OUT} = {A,C}.
- RSH: {OUT,SC_OUT} = {0,A}.
- RSHC: {OUT,SC_OUT} = {C,A}.
- XOR/AND/OR: bitwise result into OUT; SC_OUT cleared.
- CMP: BEQ = (A==B); BGT = (A>B), unsigned or signed per SIGNED_CMP; OUT = 0; SC_OUT holds.
- MUL: unsigned shift-add multiply, one bit per cycle. {OUT_HI,OUT} = A*B. SC_OUT = |OUT_HI.
- SHLN/SHRN: logical shift by N = B[$clog2(WIDTH)-1:0], one bit per cycle. SC_OUT = last bit shifted out. N=0 gives OUT=A with SC_OUT held.
- Flag scope: BEQ/BGT change only on CMP. OUT_HI changes only on MUL.
- Reserved opcodes (14, 15): OUT = 0, flags hold, DONE still pulses.
- FSM states:
  - IDLE → MUL on START with OP=MUL.
  - IDLE → SHIFT on START with OP=SHLN/SHRN and N>0.
  - All other accepted STARTs stay in IDLE and update outputs at the next edge.
  - MUL → IDLE when the iteration counter reaches WIDTH.
  - SHIFT → IDLE when the counter reaches N.
- START while BUSY=1 is ignored, with no side effects.

## Timing
- Reset, immediate and asynchronous, mid-operation included: state IDLE, counter 0, OUT=0, OUT_HI=0, SC_OUT=0, BEQ=0, BGT=0, BUSY=0, DONE=0. Any in-flight operation is aborted, with no DONE.
- Single-cycle operations: START sampled at edge e; OUT, flags and DONE are valid after e. BUSY never rises.
- MUL: BUSY high after edge e for exactly WIDTH cycles. DONE after edge e+WIDTH, coincident with BUSY falling.
- SHLN/SHRN with N>0: BUSY for N cycles; DONE after edge e+N.
- DONE is high for exactly one cycle.
- Back-to-back issue: START may be asserted in the DONE cycle and is accepted, so throughput is one op per clock for single-cycle ops.
- OUT is not updated during iteration; intermediate values live in internal registers.

## Structure
- Package definitions holds:
  - alu_op_t, 4-bit enum: kADD=0, kSUB=1, kADDi=2, kLSH=3, kLSHC=4, kRSH=5, kRSHC=6, kXOR=7, kAND=8, kOR=9, kCMP=10, kMUL=11, kSHLN=12, kSHRN=13.
  - alu_state_t: IDLE, MUL, SHIFT.
- Sub-module alu_mul_iter holds the multiplier: accumulator, multiplier shift register and counter, with start/done handshake to the parent.
- Shift-by-N iteration stays in the parent.

## Test plan
- Chained add, WIDTH=8: ADD 0xFF+0x01 → OUT=0x00, SC_OUT=1. Then ADD USE_CARRY=1, 0x00+0x00 → OUT=0x01, SC_OUT=0.
- SUB with borrow: 0x05−0x07 → OUT=0xFE, SC_OUT=0. Then SUB USE_CARRY=1, 0x10−0x00 → OUT=0x0F.
- CMP: A=0x80, B=0x01. With SIGNED_CMP=0 → BGT=1, BEQ=0. With SIGNED_CMP=1 → BGT=0. OUT=0; SC_OUT unchanged.
- MUL 0xFF×0xFF → after 8 BUSY cycles, DONE with OUT_HI=0xFE, OUT=0x01, SC_OUT=1. A START during BUSY is ignored.
- SHRN 0x81 by B=3 → BUSY 3 cycles, OUT=0x10, SC_OUT=0. SHLN by B=0 → DONE next cycle, OUT=A.
- Reset: assert RST_N=0 mid-MUL, asynchronously → all outputs 0 immediately, no DONE. After release, ADDi 0x03+IMM 0x1F → OUT=0x22.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encoding and controller states.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        kADD  = 4'd0,
        kSUB  = 4'd1,
        kADDi = 4'd2,
        kLSH  = 4'd3,
        kLSHC = 4'd4,
        kRSH  = 4'd5,
        kRSHC = 4'd6,
        kXOR  = 4'd7,
        kAND  = 4'd8,
        kOR   = 4'd9,
        kCMP  = 4'd10,
        kMUL  = 4'd11,
        kSHLN = 4'd12,
        kSHRN = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SHIFT
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier retiring one multiplier bit per clock.
// done and the product are presented combinationally on the final iteration cycle.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q;
    logic [WIDTH:0]   sum;

    // Low product bits shift into the vacated top of the multiplier register.
    always_comb begin
        sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d    = sum[WIDTH:1];
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
    end

    assign done    = run_q && (cnt_d == CNT_LAST);
    assign prod_hi = acc_d;
    assign prod_lo = mplier_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            mcand_q  <= a;
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative multiply and shift-by-N,
// with carry/equal/greater flags kept internally for multi-precision chaining.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned IMM_W      = 5,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  alu_op_t          OP,
    input  logic [WIDTH-1:0] INPUTA,
    input  logic [WIDTH-1:0] INPUTB,
    input  logic [IMM_W-1:0] IMM,
    input  logic             USE_CARRY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_HI,
    output logic             SC_OUT,
    output logic             BEQ,
    output logic             BGT
);

    localparam int unsigned NW = $clog2(WIDTH);

    alu_state_t       state_q;
    logic [NW-1:0]    cnt_q, n_q;
    logic [WIDTH-1:0] sh_q, sh_next;
    logic             dir_left_q, sh_bit;
    logic [WIDTH-1:0] out_q, out_hi_q;
    logic             sc_q, beq_q, bgt_q, done_q;

    logic [NW-1:0]    n_in;
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_lo, mul_hi;

    logic [WIDTH-1:0] add_b;
    logic             cin;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] res_out;
    logic             res_sc, res_beq, res_bgt;

    assign n_in      = INPUTB[NW-1:0];
    assign mul_start = START && (state_q == IDLE) && (OP == kMUL);

    assign BUSY   = (state_q != IDLE);
    assign DONE   = done_q;
    assign OUT    = out_q;
    assign OUT_HI = out_hi_q;
    assign SC_OUT = sc_q;
    assign BEQ    = beq_q;
    assign BGT    = bgt_q;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (CLK),
        .rst_n   (RST_N),
        .start   (mul_start),
        .a       (INPUTA),
        .b       (INPUTB),
        .done    (mul_done),
        .prod_lo (mul_lo),
        .prod_hi (mul_hi)
    );

    // Single-cycle result; SUB is A + ~B with the carry-in acting as "no borrow".
    always_comb begin
        add_b = INPUTB;
        if (OP == kSUB) begin
            add_b = ~INPUTB;
        end else if (OP == kADDi) begin
            add_b = WIDTH'(IMM);
        end

        cin = 1'b0;
        if (OP != kADDi) begin
            cin = USE_CARRY ? sc_q : (OP == kSUB);
        end
        add_sum = {1'b0, INPUTA} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};

        res_out = '0;
        res_sc  = sc_q;
        res_beq = beq_q;
        res_bgt = bgt_q;
        case (OP)
            kADD, kSUB, kADDi: {res_sc, res_out} = add_sum;
            kLSH:              {res_sc, res_out} = {INPUTA, 1'b0};
            kLSHC:             {res_sc, res_out} = {INPUTA, sc_q};
            kRSH:              {res_out, res_sc} = {1'b0, INPUTA};
            kRSHC:             {res_out, res_sc} = {sc_q, INPUTA};
            kXOR: begin
                res_out = INPUTA ^ INPUTB;
                res_sc  = 1'b0;
            end
            kAND: begin
                res_out = INPUTA & INPUTB;
                res_sc  = 1'b0;
            end
            kOR: begin
                res_out = INPUTA | INPUTB;
                res_sc  = 1'b0;
            end
            kCMP: begin
                res_beq = (INPUTA == INPUTB);
                res_bgt = SIGNED_CMP ? ($signed(INPUTA) > $signed(INPUTB)) : (INPUTA > INPUTB);
            end
            // Only reached with N=0: pass A through, carry untouched.
            kSHLN, kSHRN:      res_out = INPUTA;
            default: ;
        endcase
    end

    always_comb begin
        sh_next = dir_left_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
        sh_bit  = dir_left_q ? sh_q[WIDTH-1] : sh_q[0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            sh_q       <= '0;
            dir_left_q <= 1'b0;
            out_q      <= '0;
            out_hi_q   <= '0;
            sc_q       <= 1'b0;
            beq_q      <= 1'b0;
            bgt_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        if (OP == kMUL) begin
                            state_q <= MUL;
                        end else if ((OP == kSHLN || OP == kSHRN) && n_in != '0) begin
                            state_q    <= SHIFT;
                            sh_q       <= INPUTA;
                            n_q        <= n_in;
                            dir_left_q <= (OP == kSHLN);
                            cnt_q      <= '0;
                        end else begin
                            out_q  <= res_out;
                            sc_q   <= res_sc;
                            beq_q  <= res_beq;
                            bgt_q  <= res_bgt;
                            done_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        out_q    <= mul_lo;
                        out_hi_q <= mul_hi;
                        sc_q     <= |mul_hi;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_next;
                    cnt_q <= cnt_q + NW'(1);
                    if (cnt_q + NW'(1) == n_q) begin
                        out_q   <= sh_next;
                        sc_q    <= sh_bit;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: unsigned- and signed-compare instances share stimulus;
// a monitor pops one expected entry per DONE and checks both instances.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       use_carry = 1'b0;
    alu_op_t    op = kADD;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [4:0] imm = 5'h00;

    logic       busy0, done0, sc0, beq0, bgt0;
    logic [7:0] out0, hi0;
    logic       busy1, done1, sc1, beq1, bgt1;
    logic [7:0] out1, hi1;

    typedef struct {
        string      name;
        logic [7:0] out;
        logic [7:0] hi;
        logic [3:0] flags;  // {sc, beq, bgt_unsigned, bgt_signed}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   dones  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .IMM_W(5), .SIGNED_CMP(1'b0)) u_dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .OP(op), .INPUTA(a), .INPUTB(b),
        .IMM(imm), .USE_CARRY(use_carry), .BUSY(busy0), .DONE(done0), .OUT(out0),
        .OUT_HI(hi0), .SC_OUT(sc0), .BEQ(beq0), .BGT(bgt0)
    );

    alu_seq #(.WIDTH(8), .IMM_W(5), .SIGNED_CMP(1'b1)) u_dut_s (
        .CLK(clk), .RST_N(rst_n), .START(start), .OP(op), .INPUTA(a), .INPUTB(b),
        .IMM(imm), .USE_CARRY(use_carry), .BUSY(busy1), .DONE(done1), .OUT(out1),
        .OUT_HI(hi1), .SC_OUT(sc1), .BEQ(beq1), .BGT(bgt1)
    );

    // Monitor: sample just after each rising edge.
    always @(posedge clk) begin
        exp_t       e;
        logic [19:0] got, want;
        #1;
        if (done0) begin
            dones++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: DONE=1 with no operation pending (out=%h)", out0);
            end else begin
                e = sb.pop_front();
                got  = {out0, hi0, sc0, beq0, bgt0, 1'b1};
                want = {e.out, e.hi, e.flags[3], e.flags[2], e.flags[1], 1'b1};
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s: got out=%h hi=%h sc=%b beq=%b bgt=%b, want out=%h hi=%h sc=%b beq=%b bgt=%b",
                             e.name, out0, hi0, sc0, beq0, bgt0,
                             e.out, e.hi, e.flags[3], e.flags[2], e.flags[1]);
                end
                checks++;
                got  = {out1, hi1, sc1, beq1, bgt1, done1};
                want = {e.out, e.hi, e.flags[3], e.flags[2], e.flags[0], 1'b1};
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s_signed: got out=%h hi=%h sc=%b beq=%b bgt=%b done=%b, want out=%h hi=%h sc=%b beq=%b bgt=%b done=1",
                             e.name, out1, hi1, sc1, beq1, bgt1, done1,
                             e.out, e.hi, e.flags[3], e.flags[2], e.flags[0]);
                end
            end
        end
    end

    task automatic issue(input alu_op_t o, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [4:0] im, input logic uc, input bit push, input string nm,
                         input logic [7:0] eo, input logic [7:0] eh, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = ia;
        b = ib;
        imm = im;
        use_carry = uc;
        if (push) begin
            e.name  = nm;
            e.out   = eo;
            e.hi    = eh;
            e.flags = ef;
            sb.push_back(e);
        end
    endtask

    // Counts BUSY cycles after an issue; optionally pokes an extra START mid-operation.
    task automatic measure(input string nm, input int exp_busy, input int poke_at);
        int   busy_n = 0;
        logic done_end = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy0) begin
                done_end = done0;
                break;
            end
            busy_n++;
            if (busy_n == poke_at) begin
                start = 1'b1;
                op = kADD;
                a = 8'h01;
                b = 8'h01;
            end
        end
        checks++;
        if (busy_n != exp_busy || done_end !== 1'b1) begin
            errors++;
            $display("FAIL %s: busy_cycles=%0d done_at_fall=%b, want busy_cycles=%0d done_at_fall=1",
                     nm, busy_n, done_end, exp_busy);
        end
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d operations never completed, want 0", nm, sb.size());
        end
    endtask

    initial begin
        int dones_before;

        #12;
        checks++;
        if ({out0, hi0, sc0, beq0, bgt0, busy0, done0} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state: got out=%h hi=%h sc=%b beq=%b bgt=%b busy=%b done=%b, want all 0",
                     out0, hi0, sc0, beq0, bgt0, busy0, done0);
        end
        checks++;
        if ({out1, hi1, sc1, beq1, bgt1, busy1, done1} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state_signed: got out=%h hi=%h sc=%b beq=%b bgt=%b, want all 0",
                     out1, hi1, sc1, beq1, bgt1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle ops issued back-to-back.
        issue(kADD,  8'hFF, 8'h01, 5'h00, 1'b0, 1'b1, "add_ff_01",    8'h00, 8'h00, 4'b1000);
        issue(kADD,  8'h00, 8'h00, 5'h00, 1'b1, 1'b1, "add_chain",    8'h01, 8'h00, 4'b0000);
        issue(kSUB,  8'h05, 8'h07, 5'h00, 1'b0, 1'b1, "sub_borrow",   8'hFE, 8'h00, 4'b0000);
        issue(kSUB,  8'h10, 8'h00, 5'h00, 1'b1, 1'b1, "sub_chain",    8'h0F, 8'h00, 4'b1000);
        issue(kCMP,  8'h80, 8'h01, 5'h00, 1'b0, 1'b1, "cmp_80_01",    8'h00, 8'h00, 4'b1010);
        issue(kCMP,  8'h42, 8'h42, 5'h00, 1'b0, 1'b1, "cmp_equal",    8'h00, 8'h00, 4'b1100);
        issue(kCMP,  8'h01, 8'h80, 5'h00, 1'b0, 1'b1, "cmp_01_80",    8'h00, 8'h00, 4'b1001);
        issue(kLSH,  8'h81, 8'h00, 5'h00, 1'b0, 1'b1, "lsh_81",       8'h02, 8'h00, 4'b1001);
        issue(kLSHC, 8'h40, 8'h00, 5'h00, 1'b0, 1'b1, "lshc_40",      8'h81, 8'h00, 4'b0001);
        issue(kRSHC, 8'h03, 8'h00, 5'h00, 1'b0, 1'b1, "rshc_03",      8'h01, 8'h00, 4'b1001);
        issue(kRSH,  8'h02, 8'h00, 5'h00, 1'b0, 1'b1, "rsh_02",       8'h01, 8'h00, 4'b0001);
        issue(kADDi, 8'hFF, 8'h00, 5'h01, 1'b0, 1'b1, "addi_ff_01",   8'h00, 8'h00, 4'b1001);
        issue(kXOR,  8'hF0, 8'h3C, 5'h00, 1'b0, 1'b1, "xor",          8'hCC, 8'h00, 4'b0001);
        issue(kAND,  8'hF0, 8'h3C, 5'h00, 1'b0, 1'b1, "and",          8'h30, 8'h00, 4'b0001);
        issue(kOR,   8'hF0, 8'h3C, 5'h00, 1'b0, 1'b1, "or",           8'hFC, 8'h00, 4'b0001);
        @(negedge clk);
        start = 1'b0;
        drain("drain_single");

        // Iterative and boundary ops, each timed.
        issue(kMUL,  8'hFF, 8'hFF, 5'h00, 1'b0, 1'b1, "mul_ff_ff",    8'h01, 8'hFE, 4'b1001);
        measure("busy_mul_ff_ff", 8, 3);
        issue(alu_op_t'(4'd14), 8'h12, 8'h34, 5'h00, 1'b0, 1'b1, "reserved_14", 8'h00, 8'hFE, 4'b1001);
        measure("busy_reserved", 0, 0);
        issue(kSHRN, 8'h81, 8'h03, 5'h00, 1'b0, 1'b1, "shrn_81_3",    8'h10, 8'hFE, 4'b0001);
        measure("busy_shrn_3", 3, 0);
        issue(kSHLN, 8'hC0, 8'h02, 5'h00, 1'b0, 1'b1, "shln_c0_2",    8'h00, 8'hFE, 4'b1001);
        measure("busy_shln_2", 2, 0);
        issue(kSHLN, 8'h5A, 8'h08, 5'h00, 1'b0, 1'b1, "shln_n0",      8'h5A, 8'hFE, 4'b1001);
        measure("busy_shln_0", 0, 0);
        issue(kMUL,  8'h0D, 8'h0B, 5'h00, 1'b0, 1'b1, "mul_0d_0b",    8'h8F, 8'h00, 4'b0001);
        measure("busy_mul_0d_0b", 8, 0);
        drain("drain_iter");

        // Asynchronous reset in the middle of a multiply.
        issue(kMUL,  8'hFF, 8'hFF, 5'h00, 1'b0, 1'b0, "mul_aborted",  8'h00, 8'h00, 4'b0000);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        dones_before = dones;
        checks++;
        if ({out0, hi0, sc0, beq0, bgt0, busy0, done0} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset: got out=%h hi=%h sc=%b beq=%b bgt=%b busy=%b done=%b, want all 0",
                     out0, hi0, sc0, beq0, bgt0, busy0, done0);
        end
        checks++;
        if ({out1, hi1, sc1, beq1, bgt1, busy1, done1} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset_signed: got out=%h hi=%h sc=%b beq=%b bgt=%b busy=%b, want all 0",
                     out1, hi1, sc1, beq1, bgt1, busy1);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (dones != dones_before || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got dones=%0d busy=%b, want dones=%0d busy=0",
                     dones, busy0, dones_before);
        end

        issue(kADDi, 8'h03, 8'h00, 5'h1F, 1'b0, 1'b1, "addi_after_rst", 8'h22, 8'h00, 4'b0000);
        issue(kADD,  8'h01, 8'h02, 5'h00, 1'b0, 1'b1, "b2b_add",        8'h03, 8'h00, 4'b0000);
        issue(kSUB,  8'h03, 8'h01, 5'h00, 1'b0, 1'b1, "b2b_sub",        8'h02, 8'h00, 4'b1000);
        @(negedge clk);
        start = 1'b0;
        drain("drain_final");
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
